// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the floating-point adder datapath.
// Provides the field widths, the unpacked-operand struct and a helper
// that splits a raw binary32 word into sign, effective exponent,
// significand with hidden bit, and class bits.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int SIG_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS = 127;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] mant;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
  } fp_op_t;

  // Denormals and zeros share the exponent of the smallest normal (1)
  // with the hidden bit cleared, so alignment needs no special case.
  function automatic fp_op_t fp_unpack(input logic [31:0] x);
    fp_op_t u;
    logic [EXP_W-1:0] e;
    logic [FRAC_W-1:0] f;
    e = x[30:23];
    f = x[22:0];
    u.sign = x[31];
    u.eff_exp = (e == '0) ? 8'd1 : e;
    u.mant = {(e != '0), f};
    u.is_nan = (e == EXP_MAX) && (f != '0);
    u.is_inf = (e == EXP_MAX) && (f == '0);
    u.is_zero = (e == '0) && (f == '0);
    return u;
  endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Handshake channels around the alignment stage.
//   fp_in_if  : operand pair (in_valid/in_ready, a, b).
//               master = operand source, slave = alignment stage.
//   fp_out_if : aligned result (out_valid/out_ready plus result fields and
//               special-case flags). master = alignment stage, slave = adder core.
interface fp_in_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;

  modport master (output in_valid, output a, output b, input in_ready);
  modport slave  (input in_valid, input a, input b, output in_ready);
endinterface

interface fp_out_if #(
  parameter int MANT_W = 24,
  parameter int GRS_W  = 3
);
  logic                      out_valid;
  logic                      out_ready;
  logic                      big_sign;
  logic [7:0]                big_exp;
  logic [MANT_W-1:0]         big_mant;
  logic [MANT_W+GRS_W-1:0]   small_mant;
  logic                      eff_sub;
  logic                      nan_flag;
  logic                      inf_flag;
  logic                      zero_flag;

  modport master (
    output out_valid, output big_sign, output big_exp, output big_mant,
    output small_mant, output eff_sub, output nan_flag, output inf_flag,
    output zero_flag, input out_ready
  );
  modport slave (
    input out_valid, input big_sign, input big_exp, input big_mant,
    input small_mant, input eff_sub, input nan_flag, input inf_flag,
    input zero_flag, output out_ready
  );
endinterface

// File: rtl/fp_sticky_shifter.sv
// Combinational right shifter for the smaller significand.
// Ports:
//   sig     in  significand with hidden bit
//   shamt   in  exponent difference (0..255)
//   aligned out {sig, GRS zeros} >> shamt, every shifted-out bit ORed into bit 0
module fp_sticky_shifter #(
  parameter int MANT_W = 24,
  parameter int GRS_W  = 3
) (
  input  logic [MANT_W-1:0]       sig,
  input  logic [7:0]              shamt,
  output logic [MANT_W+GRS_W-1:0] aligned
);

  localparam int AL_W = MANT_W + GRS_W;

  logic [AL_W-1:0] ext;
  logic [AL_W-1:0] shifted;
  logic [AL_W-1:0] lost_mask;

  always_comb begin
    ext = {sig, {GRS_W{1'b0}}};
    shifted = '0;
    lost_mask = '0;
    aligned = '0;
    if (shamt >= 8'(AL_W)) begin
      // Everything falls off the end; only the sticky bit survives.
      aligned = {{(AL_W-1){1'b0}}, |sig};
    end else begin
      shifted = ext >> shamt;
      lost_mask = (AL_W'(1) << shamt) - AL_W'(1);
      aligned = shifted | {{(AL_W-1){1'b0}}, |(ext & lost_mask)};
    end
  end

endmodule

// File: rtl/fp_align_stage.sv
// Pre-alignment stage for the sequential binary32 adder.
// Two-stage pipeline: S1 unpacks, classifies and orders the operands by
// magnitude; S2 right-shifts the smaller significand into GRS form.
// Ports:
//   clk     in  clock, all state on the rising edge
//   rst     in  synchronous active-low reset
//   in_ch   slave side of the operand channel (in_valid/in_ready, a, b)
//   out_ch  master side of the result channel (out_valid/out_ready, big_*,
//           small_mant, eff_sub, nan/inf/zero flags)
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int GRS_W  = 3
) (
  input  logic     clk,
  input  logic     rst,
  fp_in_if.slave   in_ch,
  fp_out_if.master out_ch
);

  fp_op_t ua;
  fp_op_t ub;
  logic   a_ge;
  logic [7:0] diff;
  logic   nan_c;
  logic   s2_adv;
  logic   s1_adv;

  logic              s1_valid;
  logic              s1_big_sign;
  logic [7:0]        s1_big_exp;
  logic [MANT_W-1:0] s1_big_mant;
  logic [MANT_W-1:0] s1_small_mant;
  logic [7:0]        s1_diff;
  logic              s1_eff_sub;
  logic              s1_nan;
  logic              s1_inf;
  logic              s1_zero;

  logic [MANT_W+GRS_W-1:0] shift_out;

  assign s2_adv = !out_ch.out_valid || out_ch.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ch.in_ready = s1_adv;

  always_comb begin
    ua = fp_unpack(in_ch.a);
    ub = fp_unpack(in_ch.b);
    // Magnitude order on {exp,frac}; ties go to A.
    a_ge = in_ch.a[30:0] >= in_ch.b[30:0];
    diff = a_ge ? (ua.eff_exp - ub.eff_exp) : (ub.eff_exp - ua.eff_exp);
    nan_c = ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign ^ ub.sign));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid      <= 1'b0;
      s1_big_sign   <= 1'b0;
      s1_big_exp    <= '0;
      s1_big_mant   <= '0;
      s1_small_mant <= '0;
      s1_diff       <= '0;
      s1_eff_sub    <= 1'b0;
      s1_nan        <= 1'b0;
      s1_inf        <= 1'b0;
      s1_zero       <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_ch.in_valid;
      if (in_ch.in_valid) begin
        s1_big_sign   <= a_ge ? ua.sign : ub.sign;
        s1_big_exp    <= a_ge ? ua.eff_exp : ub.eff_exp;
        s1_big_mant   <= a_ge ? ua.mant : ub.mant;
        s1_small_mant <= a_ge ? ub.mant : ua.mant;
        s1_diff       <= diff;
        s1_eff_sub    <= ua.sign ^ ub.sign;
        s1_nan        <= nan_c;
        s1_inf        <= (ua.is_inf || ub.is_inf) && !nan_c;
        s1_zero       <= ua.is_zero && ub.is_zero;
      end
    end
  end

  fp_sticky_shifter #(
    .MANT_W(MANT_W),
    .GRS_W (GRS_W)
  ) u_shifter (
    .sig    (s1_small_mant),
    .shamt  (s1_diff),
    .aligned(shift_out)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_ch.out_valid  <= 1'b0;
      out_ch.big_sign   <= 1'b0;
      out_ch.big_exp    <= '0;
      out_ch.big_mant   <= '0;
      out_ch.small_mant <= '0;
      out_ch.eff_sub    <= 1'b0;
      out_ch.nan_flag   <= 1'b0;
      out_ch.inf_flag   <= 1'b0;
      out_ch.zero_flag  <= 1'b0;
    end else if (s2_adv) begin
      out_ch.out_valid <= s1_valid;
      if (s1_valid) begin
        out_ch.big_sign   <= s1_big_sign;
        out_ch.big_exp    <= s1_big_exp;
        out_ch.big_mant   <= s1_big_mant;
        out_ch.small_mant <= shift_out;
        out_ch.eff_sub    <= s1_eff_sub;
        out_ch.nan_flag   <= s1_nan;
        out_ch.inf_flag   <= s1_inf;
        out_ch.zero_flag  <= s1_zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: per-vector latency and result checks,
// a back-to-back stream with a downstream stall, and reset of a full pipe.
module tb_fp_align_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  fp_in_if in_bus ();
  fp_out_if #(.MANT_W(24), .GRS_W(3)) out_bus ();

  fp_align_stage #(.MANT_W(24), .GRS_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_ch (in_bus),
    .out_ch(out_bus)
  );

  always #5 clk = ~clk;

  localparam int NV = 9;
  logic [31:0] va   [NV];
  logic [31:0] vb   [NV];
  logic [63:0] vexp [NV];

  function automatic logic [63:0] pack_res(input logic s, input logic [7:0] e,
                                           input logic [23:0] bm, input logic [26:0] sm,
                                           input logic sub, input logic n,
                                           input logic i, input logic z);
    return {s, e, bm, sm, sub, n, i, z};
  endfunction

  function automatic logic [63:0] observed();
    return pack_res(out_bus.big_sign, out_bus.big_exp, out_bus.big_mant,
                    out_bus.small_mant, out_bus.eff_sub, out_bus.nan_flag,
                    out_bus.inf_flag, out_bus.zero_flag);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int cyc;
    int seen;
    logic [63:0] snap;

    va[0] = 32'h40a851ec; vb[0] = 32'hc18c6666;
    vexp[0] = pack_res(1'b1, 8'h83, 24'h8C6666, 27'h150A3D8, 1'b1, 1'b0, 1'b0, 1'b0);
    va[1] = 32'h41139168; vb[1] = 32'h45afe8cd;
    vexp[1] = pack_res(1'b0, 8'h8B, 24'hAFE8CD, 27'h0024E45, 1'b0, 1'b0, 1'b0, 1'b0);
    va[2] = 32'h7F7FFFFF; vb[2] = 32'h3F800000;
    vexp[2] = pack_res(1'b0, 8'hFE, 24'hFFFFFF, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);
    va[3] = 32'h7F800000; vb[3] = 32'hFF800000;
    vexp[3] = pack_res(1'b0, 8'hFF, 24'h800000, 27'h4000000, 1'b1, 1'b1, 1'b0, 1'b0);
    va[4] = 32'h7F800000; vb[4] = 32'h3F800000;
    vexp[4] = pack_res(1'b0, 8'hFF, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b1, 1'b0);
    va[5] = 32'h00000000; vb[5] = 32'h00000000;
    vexp[5] = pack_res(1'b0, 8'h01, 24'h000000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b1);
    va[6] = 32'h00000001; vb[6] = 32'h00800000;
    vexp[6] = pack_res(1'b0, 8'h01, 24'h800000, 27'h0000008, 1'b0, 1'b0, 1'b0, 1'b0);
    va[7] = 32'h3F800000; vb[7] = 32'h4C000000;
    vexp[7] = pack_res(1'b0, 8'h98, 24'h800000, 27'h0000002, 1'b0, 1'b0, 1'b0, 1'b0);
    va[8] = 32'h4D000000; vb[8] = 32'h3F800000;
    vexp[8] = pack_res(1'b0, 8'h9A, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b0;
    in_bus.in_valid = 1'b0;
    in_bus.a = '0;
    in_bus.b = '0;
    out_bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(out_bus.out_valid), 64'd0);
    chk("rst_data", observed(), 64'd0);
    chk("rst_ready", 64'(in_bus.in_ready), 64'd1);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_bus.a = va[i];
      in_bus.b = vb[i];
      in_bus.in_valid = 1'b1;
      #1 chk($sformatf("v%0d_ready", i), 64'(in_bus.in_ready), 64'd1);
      @(negedge clk);
      in_bus.in_valid = 1'b0;
      #1 chk($sformatf("v%0d_lat1", i), 64'(out_bus.out_valid), 64'd0);
      @(negedge clk);
      #1 chk($sformatf("v%0d_lat2", i), 64'(out_bus.out_valid), 64'd1);
      chk($sformatf("v%0d_data", i), observed(), vexp[i]);
    end

    // Stream with downstream stall on cycles 3..6.
    @(negedge clk);
    sent = 0;
    got = 0;
    cyc = 0;
    snap = '0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      out_bus.out_ready = !(cyc >= 3 && cyc <= 6);
      in_bus.in_valid = (sent < 4);
      if (sent < 4) begin
        in_bus.a = va[sent];
        in_bus.b = vb[sent];
      end
      #1;
      if (cyc == 3) begin
        snap = observed();
        chk("stall_ready_c3", 64'(in_bus.in_ready), 64'd0);
        chk("stall_head", snap, vexp[0]);
      end
      if (cyc == 6) begin
        chk("stall_hold", observed(), snap);
        chk("stall_ready_c6", 64'(in_bus.in_ready), 64'd0);
        chk("stall_valid", 64'(out_bus.out_valid), 64'd1);
        chk("stall_sent", 64'(sent), 64'd2);
      end
      if (in_bus.in_valid && in_bus.in_ready) sent++;
      if (out_bus.out_valid && out_bus.out_ready) begin
        chk($sformatf("stream%0d", got), observed(), vexp[got]);
        got++;
      end
    end
    in_bus.in_valid = 1'b0;
    chk("stream_count", 64'(got), 64'd4);
    @(negedge clk);
    #1 chk("stream_drain", 64'(out_bus.out_valid), 64'd0);

    // Fill the pipe under stall, then reset it.
    @(negedge clk);
    out_bus.out_ready = 1'b0;
    in_bus.a = va[0];
    in_bus.b = vb[0];
    in_bus.in_valid = 1'b1;
    @(negedge clk);
    in_bus.a = va[1];
    in_bus.b = vb[1];
    @(negedge clk);
    in_bus.in_valid = 1'b0;
    #1;
    chk("full_ready", 64'(in_bus.in_ready), 64'd0);
    chk("full_valid", 64'(out_bus.out_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst2_valid", 64'(out_bus.out_valid), 64'd0);
    chk("rst2_data", observed(), 64'd0);
    chk("rst2_ready", 64'(in_bus.in_ready), 64'd1);
    rst = 1'b1;
    out_bus.out_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (out_bus.out_valid) seen++;
    end
    chk("rst2_no_stale", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_stage.md
Name: fp_align_stage

Overview:
- Upstream pre-alignment stage for the sequential single-precision floating-point adder.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake.
- Unpacks and classifies both operands, orders them by magnitude, and right-shifts the smaller significand into a 27-bit aligned form (guard/round/sticky appended).
- The adder core then only needs to add or subtract, normalise and round.

Parameters:
- MANT_W, 24, significand width including hidden bit.
- GRS_W, 3, extra low bits (guard, round, sticky) on the aligned small significand.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
- in_valid  in  1  operand pair present.
- in_ready  out  1  stage can accept the pair this cycle.
- a  in  32  operand A, binary32.
- b  in  32  operand B, binary32.
- out_valid  out  1  aligned result present.
- out_ready  in  1  downstream accepts this cycle.
- big_sign  out  1  sign of the larger-magnitude operand.
- big_exp  out  8  effective exponent of the larger operand (denormal/zero reported as 1).
- big_mant  out  24  larger significand with hidden bit.
- small_mant  out  27  smaller significand, hidden bit, <<3 then right-shifted by the exponent difference, sticky ORed into bit 0.
- eff_sub  out  1  sign(a) XOR sign(b).
- nan_flag  out  1  either input NaN, or +inf plus -inf.
- inf_flag  out  1  result is infinite (at least one inf and not nan_flag).
- zero_flag  out  1  both operands are ±0.

Behaviour:
- Two-stage pipeline; each stage has a valid bit and a data register.
  - S1 (unpack/compare): registers fields, class bits, swap decision and 8-bit exponent difference.
  - S2 (shift): registers all outputs.
- Latency: 2 cycles from in_valid&&in_ready to out_valid with no backpressure. Throughput: 1 pair/cycle.
- Handshake:
  - s2 advances when !out_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = s1 advance condition (combinational from out_ready, no registered skid).
  - While out_valid && !out_ready, all outputs hold stable.
  - A transfer occurs only when valid && ready are both 1 in the same cycle.
- Unpack:
  - exp==0 → effective exponent 1, hidden bit 0.
  - Otherwise hidden bit 1.
  - exp==255 with frac!=0 → NaN; exp==255 with frac==0 → inf.
- Ordering: compare {exp,frac} unsigned. A is "big" when A >= B, so on a tie A is big.
- Shift:
  - d = big_eff_exp − small_eff_exp (0..254).
  - If d >= 27: small_mant = {26'b0, sticky}, where sticky = |small significand.
  - Else: small_mant = ({sig,3'b0} >> d) | {26'b0, OR of shifted-out bits}.
- Specials: flags are computed in S1 and carried through. Data fields are still produced but the consumer ignores them when nan_flag or inf_flag is set.
- Reset (rst==0 at a clk edge):
  - All valid bits and every output register go to 0; in_ready reads 1 the next cycle.
  - Any in-flight pair is discarded with no partial output.
  - Reset during a stall drops the stalled result.
- Simultaneous events:
  - Input accept and output consume in the same cycle are both honoured and the pipeline stays full.
  - in_valid while in_ready==0 is ignored; the source must hold it.

Decomposition:
- Shared package fp_pkg:
  - constants EXP_W=8, FRAC_W=23, EXP_MAX=8'hFF, BIAS=127.
  - unpacked-operand struct {sign, eff_exp, mant, is_nan, is_inf, is_zero}.
  - Also reused by the adder core.
- One sub-module, fp_sticky_shifter: combinational 27-bit right shift with saturation at 27 and sticky OR, instantiated in S2.

Test Plan:
- a=40a851ec, b=c18c6666, out_ready=1 → after 2 cycles:
  - big_sign=1, big_exp=0x83, big_mant=0x8C6666, small_mant=0x150A3D8, eff_sub=1, all flags 0.
- a=41139168, b=45afe8cd → big_exp=0x8B, big_mant=0xAFE8CD, d=9, small_mant=0x0024E45 (sticky set), eff_sub=0.
- a=7F7FFFFF, b=3F800000 → d=127 saturates: small_mant=0x0000001, big_mant=0xFFFFFF, big_exp=0xFE.
- a=7F800000, b=FF800000 → nan_flag=1. Next pair a=7F800000, b=3F800000 → inf_flag=1, nan_flag=0. a=0, b=0 → zero_flag=1, big_exp=0x01.
- Stream 4 pairs back-to-back with out_ready held 0 for cycles 3–6:
  - in_ready drops after 2 accepted pairs; outputs stay frozen.
  - All 4 results emerge in order with no loss or duplication once out_ready=1.
- Fill the pipeline, then assert rst=0 for 1 cycle → out_valid=0 and all outputs 0 the next cycle; in_ready=1; no stale result appears afterwards.
